// File: rtl/drygascon_mix.sv
// DrySPONGE mix stage: absorbs {ds, in_data} into the 320-bit capacity, 10 bits per step,
// with an external core round between steps. Optional macro DRYMIX_ZEROIZE_EN clears state on hand-off.
module drygascon_mix #(
  parameter int CWIDTH      = 320,
  parameter int IWIDTH      = 128,
  parameter int DSWIDTH     = 4,
  parameter int XWIDTH      = 128,
  parameter int ROUND_COUNT = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [CWIDTH-1:0]      c_in,
  input  logic [IWIDTH-1:0]      in_data,
  input  logic [DSWIDTH-1:0]     ds,
  input  logic [XWIDTH-1:0]      x,
  output logic                   busy,
  output logic [CWIDTH-1:0]      core_c,
  output logic [ROUND_COUNT-1:0] core_round,
  output logic                   core_en,
  output logic                   core_rst,
  input  logic [CWIDTH-1:0]      core_cout,
  input  logic                   core_done,
  output logic [CWIDTH-1:0]      c_out,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int NSTEPS = 14;
  localparam int MWIDTH = 10 * NSTEPS;

  // Handshake: c_out transfers on a cycle where out_valid && out_ready; out_valid
  // stays high with c_out stable until that cycle, and out_ready alone does nothing.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    XOR       = 3'd1,
    CORE_RST  = 3'd2,
    WAIT_CORE = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t              state, state_nx;
  logic [CWIDTH-1:0]   c_reg;
  logic [MWIDTH-1:0]   m_reg;
  logic [3:0]          step;
  logic [9:0]          chunk;
  logic [CWIDTH-1:0]   c_xor;

  assign chunk = m_reg[10*int'(step) +: 10];

  // Each 2-bit field of the chunk picks which X word hits the low half of a capacity word.
  always_comb begin
    c_xor = c_reg;
    for (int k = 0; k < 5; k++) begin
      c_xor[64*k +: 32] = c_reg[64*k +: 32] ^ x[32*int'(chunk[2*k +: 2]) +: 32];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = (state != IDLE);
    core_c     = c_reg;
    core_round = '0;
    core_en    = 1'b0;
    core_rst   = 1'b0;
    out_valid  = 1'b0;
    c_out      = '0;
    case (state)
      IDLE:      if (start) state_nx = XOR;
      XOR:       state_nx = (step == 4'(NSTEPS - 1)) ? HOLD : CORE_RST;
      CORE_RST: begin
        core_rst = 1'b1;
        state_nx = WAIT_CORE;
      end
      WAIT_CORE: begin
        core_en = 1'b1;
        if (core_done) state_nx = XOR;
      end
      HOLD: begin
        out_valid = 1'b1;
        c_out     = c_reg;
        if (out_ready) state_nx = IDLE;
      end
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_reg <= '0;
      m_reg <= '0;
      step  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          c_reg <= c_in;
          m_reg <= MWIDTH'({ds, in_data});
          step  <= '0;
        end
        XOR:  c_reg <= c_xor;
        WAIT_CORE: if (core_done) begin
          c_reg <= core_cout;
          step  <= step + 4'd1;
        end
        HOLD: if (out_ready) begin
`ifdef DRYMIX_ZEROIZE_EN
          c_reg <= '0;
          m_reg <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_drygascon_mix.sv
// Self-checking bench for drygascon_mix: random mixes against a chunk-by-chunk reference model,
// with a configurable-latency core model, HOLD back-pressure, ignored starts and mid-run reset.
module tb_drygascon_mix;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [319:0] c_in = '0;
  logic [127:0] in_data = '0;
  logic [3:0]   ds = '0;
  logic [127:0] x = '0;
  logic         busy;
  logic [319:0] core_c;
  logic [9:0]   core_round;
  logic         core_en;
  logic         core_rst;
  logic [319:0] core_cout;
  logic         core_done;
  logic [319:0] c_out;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  drygascon_mix dut (
    .clk(clk), .reset_n(reset_n), .start(start), .c_in(c_in), .in_data(in_data), .ds(ds),
    .x(x), .busy(busy), .core_c(core_c), .core_round(core_round), .core_en(core_en),
    .core_rst(core_rst), .core_cout(core_cout), .core_done(core_done), .c_out(c_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Core round model: either pass-through or a rotate+constant scramble, done after core_lat enabled cycles.
  int core_lat = 1;
  bit core_scr = 1'b0;
  bit done_noise = 1'b0;
  int core_cnt = 0;
  int rst_pulses = 0;

  function automatic logic [319:0] core_fn(input logic [319:0] c, input bit scr);
    if (scr) return {c[312:0], c[319:313]} ^ {5{64'h9e3779b97f4a7c15}};
    return c;
  endfunction

  always @(posedge clk) begin
    if (core_rst) begin
      core_cnt <= 0;
      rst_pulses <= rst_pulses + 1;
    end else if (core_en) core_cnt <= core_cnt + 1;
  end

  assign core_cout = core_fn(core_c, core_scr);
  assign core_done = core_en ? (core_cnt == core_lat - 1) : done_noise;

  // Reference: 14 chunks of {pad, ds, in_data}; chunk field k selects the X word for word k; core between chunks.
  function automatic logic [319:0] mix_model(input logic [319:0] c0, input logic [127:0] d,
                                             input logic [3:0] s_ds, input logic [127:0] kx,
                                             input bit scr);
    logic [319:0] c;
    logic [139:0] m;
    logic [1:0]   sel;
    c = c0;
    m = {8'h00, s_ds, d};
    for (int s = 0; s < 14; s++) begin
      for (int k = 0; k < 5; k++) begin
        sel = m[10*s + 2*k +: 2];
        c[64*k +: 32] = c[64*k +: 32] ^ kx[32*sel +: 32];
      end
      if (s < 13) c = core_fn(c, scr);
    end
    return c;
  endfunction

  logic [319:0] last_cout;

  task automatic run_mix(input logic [319:0] ci, input logic [127:0] d, input logic [3:0] s_ds,
                         input logic [127:0] kx, input int lat, input bit scr,
                         input int hold_cycles, input bit start_with_ready);
    logic [319:0] exp;
    int n;
    int bad;
    exp = mix_model(ci, d, s_ds, kx, scr);
    core_lat = lat;
    core_scr = scr;
    @(negedge clk);
    c_in = ci; in_data = d; ds = s_ds; x = kx; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rst_pulses = 0;
    n = 0;
    bad = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (out_valid) break;
      if (!busy || c_out !== '0 || core_round !== '0) bad++;
      n++;
      // Noise while busy: starts with fresh operands, stray out_ready and core_done.
      start = ($urandom_range(0, 3) == 0);
      c_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in_data = {$urandom, $urandom, $urandom, $urandom};
      ds = 4'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      done_noise = $urandom_range(0, 1);
    end
    start = 1'b0;
    out_ready = 1'b0;
    check("latency", 320'(n), 320'(14 + 13 * (1 + lat)));
    check("core_rst_pulses", 320'(rst_pulses), 320'd13);
    check("busy_no_output", 320'(bad), 320'd0);
    check("c_out", c_out, exp);
    last_cout = c_out;
    bad = 0;
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      if (!out_valid || c_out !== exp) bad++;
    end
    check("hold_stable", 320'(bad), 320'd0);
    out_ready = 1'b1;
    start = start_with_ready;
    @(posedge clk);
    #1 out_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("after_handshake", {busy, out_valid, c_out}, '0);
`ifdef DRYMIX_ZEROIZE_EN
    check("creg_after", dut.c_reg, '0);
`else
    check("creg_after", dut.c_reg, exp);
`endif
  endtask

  initial begin
    int n;
    #13;
    check("reset_ctl", 320'({busy, out_valid, core_en, core_rst, core_round}), '0);
    check("reset_c_out", c_out, '0);
    check("reset_core_c", core_c, '0);
    @(negedge clk);
    reset_n = 1'b1;

    run_mix('0, '0, 4'h0, '0, 1, 1'b0, 2, 1'b0);
    check("t1_zero", last_cout, '0);
    run_mix('0, '0, 4'h0, {32'h4, 32'h3, 32'h2, 32'h1}, 1, 1'b0, 0, 1'b0);
    check("t2_cancel", last_cout, '0);
    run_mix('0, 128'h1, 4'h0, {32'h4, 32'h3, 32'h2, 32'h1}, 1, 1'b0, 0, 1'b1);
    check("t2_word0", 320'(last_cout[31:0]), 320'h3);
    run_mix('0, '0, 4'hF, {32'hdddd0004, 32'hcccc0003, 32'hbbbb0002, 32'haaaa0001}, 1, 1'b0, 1, 1'b0);
    run_mix({10{$urandom}}, {4{$urandom}}, 4'hA, {4{$urandom}}, 5, 1'b1, 20, 1'b1);

    for (int t = 0; t < 8; t++) begin
      run_mix({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 4'($urandom),
              {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(1, 6), 1'($urandom), $urandom_range(0, 5), 1'($urandom));
    end

    // Abort in WAIT_CORE at step 6, then a fresh mix must be clean.
    core_lat = 3;
    @(negedge clk);
    c_in = {10{$urandom}}; in_data = {4{$urandom}}; x = {4{$urandom}}; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (n < 2000 && !(dut.step == 4'd6 && core_en)) begin
      @(negedge clk);
      n++;
    end
    check("reach_step6", 320'(n < 2000), 320'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_ctl", 320'({busy, out_valid, core_en, core_rst, core_round}), '0);
    check("abort_c_out", c_out, '0);
    check("abort_core_c", core_c, '0);
    @(negedge clk);
    reset_n = 1'b1;
    run_mix({10{$urandom}}, {4{$urandom}}, 4'h5, {4{$urandom}}, 2, 1'b1, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
